ahbl_splitter: RTL and testbench
================================

# ahbl_splitter

Parametrised AHB-Lite 1-to-N address-decoding splitter. It sits between a single AHB-Lite manager (the processor bus port) and N AHB-Lite subordinates (SRAM, peripheral bridges, and so on). It replaces the direct manager-to-single-SRAM connection. It decodes each address phase against a per-port base/mask map and tracks the active data phase. It multiplexes the response back upstream, and answers any transfer that matches no port with a two-cycle AHB ERROR response from an internal default subordinate.

## Interface
Parameters:
- N_PORTS, 2, number of downstream ports (1..16)
- W_ADDR, 32, address width
- W_DATA, 32, data width
- ADDR_MAP, {32'h2000_0000, 32'h0000_0000}, packed N_PORTS×W_ADDR port base addresses; port i at bits [i*W_ADDR +: W_ADDR]
- ADDR_MASK, {32'hf000_0000, 32'hf000_0000}, packed N_PORTS×W_ADDR decode masks, same packing

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- src_hready  in  1  system HREADY (address-phase qualifier)
- src_hready_resp  out  1  HREADYOUT to manager
- src_hresp  out  1  HRESP to manager
- src_haddr  in  W_ADDR  address
- src_hwrite, src_htrans[1:0], src_hsize[2:0], src_hburst[2:0], src_hprot[3:0], src_hmastlock  in  -  address-phase control
- src_hwdata  in  W_DATA  write data
- src_hrdata  out  W_DATA  read data to manager
- dst_hsel  out  N_PORTS  per-port select
- dst_hready  out  1  broadcast system HREADY (= src_hready)
- dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata  out  -  broadcast copies of the src_* equivalents
- dst_hready_resp  in  N_PORTS  per-port HREADYOUT
- dst_hresp  in  N_PORTS  per-port HRESP
- dst_hrdata  in  N_PORTS×W_DATA  per-port read data, packed like ADDR_MAP

## Operation
- Decode (combinational): match_i = ((src_haddr & MASK_i) == MAP_i). When several ports match, the lowest index wins. dst_hsel is one-hot or zero and is independent of htrans.
- Unmapped: no port matches and src_htrans[1]=1 (NONSEQ/SEQ). The transfer goes to the default subordinate. Unmapped IDLE/BUSY transfers get a zero-wait OKAY.
- Data-phase register dsel[N_PORTS:0] (bit N_PORTS = default subordinate, all-zero = no active data phase).
  - Loaded on clk when src_hready=1 with {unmapped_active, dst_hsel & {N{src_htrans[1]}}}.
  - Holds when src_hready=0.
- Response mux:
  - dsel bit i set (i<N): src_hready_resp=dst_hready_resp[i], src_hresp=dst_hresp[i], src_hrdata=dst_hrdata[i].
  - dsel all-zero: hready_resp=1, hresp=0, hrdata=0.
  - Default subordinate: hrdata=0.
- Default-subordinate FSM: ERR_IDLE → ERR_1 → ERR_2 → ERR_IDLE.
  - ERR_IDLE → ERR_1 when an unmapped active transfer is accepted (src_hready=1).
  - ERR_1 outputs hready_resp=0, hresp=1; advances unconditionally.
  - ERR_2 outputs hready_resp=1, hresp=1. If a new unmapped active transfer is accepted in this cycle, the next state is ERR_1; otherwise ERR_IDLE.
- Back-to-back transfers across ports and the default subordinate need no idle cycle. The address phase of transfer n+1 overlaps the data phase of transfer n.
- A manager may drop to IDLE in ERR_2 after an error. The splitter does not require this.

## Timing
- Reset (async assert):
  - dsel=0, FSM=ERR_IDLE.
  - Outputs: src_hready_resp=1, src_hresp=0, src_hrdata=0. dst_hsel follows src_haddr combinationally.
- Deassertion is synchronised upstream; the block needs no internal synchroniser.
- Latency: zero added cycles. Address decode and response mux are combinational; one register stage tracks the data phase.
- Unmapped transfer costs exactly 2 data-phase cycles.
- Wait states: a subordinate holding hready_resp=0 freezes dsel. The next address phase is presented continuously until src_hready=1.
- Reset mid-transfer abandons the outstanding data phase. The first post-reset cycle presents OKAY, ready.
- N_PORTS=1 is legal: a single decoder plus default subordinate.

## Test plan
- Read from 0x0000_0010 (port 0 returns 0xA5A5_0001, zero-wait) → dst_hsel=2'b01 in the address phase; src_hrdata=0xA5A5_0001, hresp=0 in the next cycle.
- Write 0x2000_0004, then read 0x0000_0008 back to back, with port 1 inserting 2 wait states → dst_hsel=10 then 01. Manager sees 2 stall cycles, then port 0 data, with no dropped or duplicated phase.
- NONSEQ read to 0x4000_0000 (unmapped) → cycle 1: hready_resp=0, hresp=1; cycle 2: hready_resp=1, hresp=1; dst_hsel=0 throughout.
- Two consecutive unmapped NONSEQs, the second accepted in ERR_2 → FSM runs ERR_1, ERR_2, ERR_1, ERR_2.
- IDLE to 0x4000_0000 → zero-wait OKAY, FSM stays in ERR_IDLE.
- Assert rst during a port-1 wait state → outputs immediately hready_resp=1, hresp=0, hrdata=0. Next transfer to port 0 completes normally.

Source files
------------

// File: rtl/ahbl_splitter_if.sv
// AHB-Lite splitter bus bundle: one upstream manager side (src_*) and N downstream
// subordinate ports (dst_*). The splitter uses the slave view, the environment the master view.
interface ahbl_splitter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    logic                        src_hready;
    logic                        src_hready_resp;
    logic                        src_hresp;
    logic [W_ADDR-1:0]           src_haddr;
    logic                        src_hwrite;
    logic [1:0]                  src_htrans;
    logic [2:0]                  src_hsize;
    logic [2:0]                  src_hburst;
    logic [3:0]                  src_hprot;
    logic                        src_hmastlock;
    logic [W_DATA-1:0]           src_hwdata;
    logic [W_DATA-1:0]           src_hrdata;

    logic [N_PORTS-1:0]          dst_hsel;
    logic                        dst_hready;
    logic [W_ADDR-1:0]           dst_haddr;
    logic                        dst_hwrite;
    logic [1:0]                  dst_htrans;
    logic [2:0]                  dst_hsize;
    logic [2:0]                  dst_hburst;
    logic [3:0]                  dst_hprot;
    logic                        dst_hmastlock;
    logic [W_DATA-1:0]           dst_hwdata;
    logic [N_PORTS-1:0]          dst_hready_resp;
    logic [N_PORTS-1:0]          dst_hresp;
    logic [N_PORTS*W_DATA-1:0]   dst_hrdata;

    modport slave (
        input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata,
        output src_hready_resp, src_hresp, src_hrdata,
        output dst_hsel, dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
               dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata,
        input  dst_hready_resp, dst_hresp, dst_hrdata
    );

    modport master (
        output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata,
        input  src_hready_resp, src_hresp, src_hrdata,
        input  dst_hsel, dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
               dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata,
        output dst_hready_resp, dst_hresp, dst_hrdata
    );
endinterface

// File: rtl/ahbl_splitter.sv
// AHB-Lite 1-to-N address-decoding splitter with a built-in default subordinate that
// answers unmapped active transfers with a two-cycle ERROR response.
module ahbl_splitter #(
    parameter int                        N_PORTS   = 2,
    parameter int                        W_ADDR    = 32,
    parameter int                        W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = {32'h2000_0000, 32'h0000_0000},
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = {32'hf000_0000, 32'hf000_0000}
) (
    input  logic           clk,
    input  logic           rst,
    ahbl_splitter_if.slave bus
);

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_1    = 2'd1,
        ERR_2    = 2'd2
    } errState_t;

    logic [N_PORTS-1:0] portMatch;
    logic [N_PORTS-1:0] decodeSel;
    logic               anyMatch;
    logic               activeTrans;
    logic               unmappedActive;
    logic [N_PORTS:0]   dsel_q;
    logic [N_PORTS:0]   dsel_d;
    errState_t          errState_q;
    errState_t          errState_d;
    logic               errReady;
    logic               errResp;

    always_comb begin
        portMatch = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            portMatch[i] = ((bus.src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR])
                            == ADDR_MAP[i*W_ADDR +: W_ADDR]);
        end
    end

    // Scanning downward lets the lowest matching index overwrite any higher one.
    always_comb begin
        decodeSel = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (portMatch[i]) begin
                decodeSel    = '0;
                decodeSel[i] = 1'b1;
            end
        end
    end

    assign anyMatch       = |portMatch;
    assign activeTrans    = bus.src_htrans[1];
    assign unmappedActive = ~anyMatch & activeTrans;

    always_comb begin
        dsel_d = dsel_q;
        if (bus.src_hready) begin
            dsel_d = {unmappedActive, decodeSel & {N_PORTS{activeTrans}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errState_q <= ERR_IDLE;
        end else begin
            errState_q <= errState_d;
        end
    end

    // ERR_1 always advances; only ERR_2 can chain straight into another error.
    always_comb begin
        errState_d = errState_q;
        case (errState_q)
            ERR_IDLE: begin
                if (unmappedActive && bus.src_hready) begin
                    errState_d = ERR_1;
                end
            end
            ERR_1: begin
                errState_d = ERR_2;
            end
            ERR_2: begin
                if (unmappedActive && bus.src_hready) begin
                    errState_d = ERR_1;
                end else begin
                    errState_d = ERR_IDLE;
                end
            end
            default: begin
                errState_d = ERR_IDLE;
            end
        endcase
    end

    always_comb begin
        errReady = 1'b1;
        errResp  = 1'b0;
        case (errState_q)
            ERR_1: begin
                errReady = 1'b0;
                errResp  = 1'b1;
            end
            ERR_2: begin
                errReady = 1'b1;
                errResp  = 1'b1;
            end
            default: begin
                errReady = 1'b1;
                errResp  = 1'b0;
            end
        endcase
    end

    // dsel_q is one-hot or zero, so at most one branch below ever fires.
    always_comb begin
        bus.src_hready_resp = 1'b1;
        bus.src_hresp       = 1'b0;
        bus.src_hrdata      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (dsel_q[i]) begin
                bus.src_hready_resp = bus.dst_hready_resp[i];
                bus.src_hresp       = bus.dst_hresp[i];
                bus.src_hrdata      = bus.dst_hrdata[i*W_DATA +: W_DATA];
            end
        end
        if (dsel_q[N_PORTS]) begin
            bus.src_hready_resp = errReady;
            bus.src_hresp       = errResp;
            bus.src_hrdata      = '0;
        end
    end

    assign bus.dst_hsel      = decodeSel;
    assign bus.dst_hready    = bus.src_hready;
    assign bus.dst_haddr     = bus.src_haddr;
    assign bus.dst_hwrite    = bus.src_hwrite;
    assign bus.dst_htrans    = bus.src_htrans;
    assign bus.dst_hsize     = bus.src_hsize;
    assign bus.dst_hburst    = bus.src_hburst;
    assign bus.dst_hprot     = bus.src_hprot;
    assign bus.dst_hmastlock = bus.src_hmastlock;
    assign bus.dst_hwdata    = bus.src_hwdata;

endmodule

// File: tb/tb_ahbl_splitter.sv
// Self-checking bench for ahbl_splitter: a per-cycle vector table plus a hand-written
// reset-during-wait-state sequence. System HREADY is looped back from the splitter's HREADYOUT.
module tb_ahbl_splitter;
    localparam int N_PORTS = 2;
    localparam int W_ADDR  = 32;
    localparam int W_DATA  = 32;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ahbl_splitter_if #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

    assign bus.src_hready = bus.src_hready_resp;

    ahbl_splitter #(
        .N_PORTS  (N_PORTS),
        .W_ADDR   (W_ADDR),
        .W_DATA   (W_DATA),
        .ADDR_MAP ({32'h2000_0000, 32'h0000_0000}),
        .ADDR_MASK({32'hf000_0000, 32'hf000_0000})
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [1:0]  subReady;
        logic [1:0]  subResp;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  expHsel;
        logic        expReady;
        logic        expResp;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [31:0] addr, logic [1:0] trans, logic write,
                                logic [1:0] subReady, logic [1:0] subResp,
                                logic [31:0] rd0, logic [31:0] rd1,
                                logic [1:0] expHsel, logic expReady, logic expResp,
                                logic [31:0] expRdata);
        vec_t v;
        v.name = name;     v.addr = addr;         v.trans = trans;     v.write = write;
        v.subReady = subReady; v.subResp = subResp; v.rd0 = rd0;      v.rd1 = rd1;
        v.expHsel = expHsel;   v.expReady = expReady; v.expResp = expResp;
        v.expRdata = expRdata;
        return v;
    endfunction

    task automatic checkVal(input string name, input string what,
                            input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, what, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.src_haddr       = v.addr;
        bus.src_htrans      = v.trans;
        bus.src_hwrite      = v.write;
        bus.src_hsize       = 3'b010;
        bus.src_hburst      = 3'b000;
        bus.src_hprot       = 4'b0011;
        bus.src_hmastlock   = 1'b0;
        bus.src_hwdata      = {v.addr[15:0], 16'hCAFE};
        bus.dst_hready_resp = v.subReady;
        bus.dst_hresp       = v.subResp;
        bus.dst_hrdata      = {v.rd1, v.rd0};
    endtask

    task automatic checkOutput(input vec_t v);
        checkVal(v.name, "hsel",      {30'd0, bus.dst_hsel},        {30'd0, v.expHsel});
        checkVal(v.name, "readyResp", {31'd0, bus.src_hready_resp}, {31'd0, v.expReady});
        checkVal(v.name, "hresp",     {31'd0, bus.src_hresp},       {31'd0, v.expResp});
        checkVal(v.name, "hrdata",    bus.src_hrdata,               v.expRdata);
        checkVal(v.name, "dstReady",  {31'd0, bus.dst_hready},      {31'd0, v.expReady});
        checkVal(v.name, "dstAddr",   bus.dst_haddr,                v.addr);
        checkVal(v.name, "dstTrans",  {30'd0, bus.dst_htrans},      {30'd0, v.trans});
        checkVal(v.name, "dstWrite",  {31'd0, bus.dst_hwrite},      {31'd0, v.write});
    endtask

    initial begin
        vec_t v;

        // Each row is one clock cycle: driven just after posedge, sampled at negedge.
        vecs.push_back(mk("reset_idle",     32'h0000_0000, IDLE,   1'b0, 2'b11, 2'b00, 32'hA5A5_0001, 32'hB0B0_0002, 2'b01, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("rd_p0_addr",     32'h0000_0010, NONSEQ, 1'b0, 2'b11, 2'b00, 32'hA5A5_0001, 32'hB0B0_0002, 2'b01, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("rd_p0_data",     32'h2000_0004, NONSEQ, 1'b1, 2'b11, 2'b00, 32'hA5A5_0001, 32'hB0B0_0002, 2'b10, 1'b1, 1'b0, 32'hA5A5_0001));
        vecs.push_back(mk("wr_p1_wait1",    32'h0000_0008, NONSEQ, 1'b0, 2'b01, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b01, 1'b0, 1'b0, 32'hB0B0_0002));
        vecs.push_back(mk("wr_p1_wait2",    32'h0000_0008, NONSEQ, 1'b0, 2'b01, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b01, 1'b0, 1'b0, 32'hB0B0_0002));
        vecs.push_back(mk("wr_p1_done",     32'h0000_0008, NONSEQ, 1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b01, 1'b1, 1'b0, 32'hB0B0_0002));
        vecs.push_back(mk("rd_p0_8_data",   32'h4000_0000, NONSEQ, 1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b00, 1'b1, 1'b0, 32'hA5A5_0008));
        vecs.push_back(mk("err1_a",         32'h4000_0000, NONSEQ, 1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b00, 1'b0, 1'b1, 32'h0));
        vecs.push_back(mk("err2_a",         32'h4000_0000, NONSEQ, 1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b00, 1'b1, 1'b1, 32'h0));
        vecs.push_back(mk("err1_b",         32'h4000_0000, IDLE,   1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b00, 1'b0, 1'b1, 32'h0));
        vecs.push_back(mk("err2_b",         32'h4000_0000, IDLE,   1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b00, 1'b1, 1'b1, 32'h0));
        vecs.push_back(mk("idle_unmapped1", 32'h4000_0000, IDLE,   1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b00, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("idle_unmapped2", 32'h4000_0000, IDLE,   1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b00, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("busy_p1",        32'h2000_0000, BUSY,   1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b10, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("seq_p1",         32'h2000_0010, SEQ,    1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hB0B0_0002, 2'b10, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("p1_err1",        32'h0000_0000, IDLE,   1'b0, 2'b01, 2'b10, 32'hA5A5_0008, 32'hC0DE_0015, 2'b01, 1'b0, 1'b1, 32'hC0DE_0015));
        vecs.push_back(mk("p1_err2",        32'h0000_0000, IDLE,   1'b0, 2'b11, 2'b10, 32'hA5A5_0008, 32'hC0DE_0015, 2'b01, 1'b1, 1'b1, 32'hC0DE_0015));
        vecs.push_back(mk("dirty_unsel",    32'h2FFF_FFFC, IDLE,   1'b0, 2'b00, 2'b11, 32'hA5A5_0008, 32'hC0DE_0015, 2'b10, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("edge_unmapped",  32'h1000_0000, IDLE,   1'b0, 2'b00, 2'b11, 32'hA5A5_0008, 32'hC0DE_0015, 2'b00, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("edge_p0_top",    32'h0FFF_FFFC, IDLE,   1'b0, 2'b11, 2'b00, 32'hA5A5_0008, 32'hC0DE_0015, 2'b01, 1'b1, 1'b0, 32'h0));

        // Reset state with busy-looking subordinate lines: the idle response must not leak them.
        v = mk("in_reset", 32'h2000_0000, NONSEQ, 1'b0, 2'b00, 2'b11, 32'h1111_1111, 32'h2222_2222, 2'b10, 1'b1, 1'b0, 32'h0);
        applyStimulus(v);
        #2;
        checkOutput(v);
        repeat (2) @(posedge clk);
        #1;
        v = mk("pre_release", 32'h0000_0000, IDLE, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 32'h0);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i]);
        end

        // Reset asserted asynchronously while port 1 is stalling the data phase.
        @(posedge clk); #1;
        v = mk("rst_p1_addr", 32'h2000_0000, NONSEQ, 1'b0, 2'b11, 2'b00, 32'h0, 32'h3333_3333, 2'b10, 1'b1, 1'b0, 32'h0);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk); #1;
        v = mk("rst_p1_wait", 32'h0000_0010, IDLE, 1'b0, 2'b01, 2'b00, 32'h0, 32'h3333_3333, 2'b01, 1'b0, 1'b0, 32'h3333_3333);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        #1 rst = 1'b1;
        #1;
        checkVal("rst_async", "readyResp", {31'd0, bus.src_hready_resp}, 32'd1);
        checkVal("rst_async", "hresp",     {31'd0, bus.src_hresp},       32'd0);
        checkVal("rst_async", "hrdata",    bus.src_hrdata,               32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        v = mk("post_rst_addr", 32'h0000_0010, NONSEQ, 1'b0, 2'b01, 2'b00, 32'h1234_5678, 32'h3333_3333, 2'b01, 1'b1, 1'b0, 32'h0);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk); #1;
        v = mk("post_rst_data", 32'h0000_0000, IDLE, 1'b0, 2'b01, 2'b00, 32'h1234_5678, 32'h3333_3333, 2'b01, 1'b1, 1'b0, 32'h1234_5678);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
